// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width and the flit-type encoding carried in the top two bits.
package noc_pkg;

    localparam int unsigned FLIT_W   = 32;
    localparam int unsigned TYPE_W   = 2;
    localparam int unsigned TYPE_MSB = FLIT_W - 1;
    localparam int unsigned TYPE_LSB = FLIT_W - TYPE_W;

    typedef enum logic [TYPE_W-1:0] {
        FLIT_EMPTY = 2'b00,
        FLIT_HEAD  = 2'b01,
        FLIT_BODY  = 2'b10,
        FLIT_TAIL  = 2'b11
    } flit_type_e;

endpackage

// File: rtl/output_port_if.sv
// Crossbar-side handshake, downstream link and status signals of one output port.
interface output_port_if #(
    parameter int unsigned FLIT_W = noc_pkg::FLIT_W,
    parameter int unsigned CNT_W  = 3
);

    logic              in_valid;
    logic [FLIT_W-1:0] in_flit;
    logic              in_ready;
    logic              out_valid;
    logic [FLIT_W-1:0] out_flit;
    logic              credit_in;
    logic [CNT_W-1:0]  credit_count;
    logic              busy;
    logic              proto_err;
    logic              credit_err;

    modport master (
        output in_valid, in_flit, credit_in,
        input  in_ready, out_valid, out_flit, credit_count, busy, proto_err, credit_err
    );

    modport slave (
        input  in_valid, in_flit, credit_in,
        output in_ready, out_valid, out_flit, credit_count, busy, proto_err, credit_err
    );

endinterface

// File: rtl/flit_fifo.sv
// Synchronous flit FIFO; pointers carry an extra wrap bit to tell full from empty.
module flit_fifo #(
    parameter int unsigned FLIT_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [FLIT_W-1:0] din,
    output logic [FLIT_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [FLIT_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_q, rd_ptr_q;
    logic              do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/output_port.sv
// Router output port: framing check on accepted flits, local FIFO, credit-gated send register.
module output_port #(
    parameter int unsigned FLIT_W     = noc_pkg::FLIT_W,
    parameter int unsigned CREDITS    = 6,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic          clk,
    input logic          rst_n,
    output_port_if.slave port
);

    import noc_pkg::*;

    localparam int unsigned CNT_W = $clog2(CREDITS + 1);

    typedef enum logic {StIdle, StPacket} state_e;

    state_e            state_q;
    logic              out_valid_q;
    logic [FLIT_W-1:0] out_flit_q;
    logic [CNT_W-1:0]  credit_q;
    logic              proto_err_q, credit_err_q;

    flit_type_e        in_type;
    logic              accept, legal, push, send;
    logic              fifo_full, fifo_empty;
    logic [FLIT_W-1:0] fifo_dout;

    always_comb begin
        in_type = flit_type_e'(port.in_flit[FLIT_W-1 -: TYPE_W]);
        accept  = port.in_valid & ~fifo_full;
        legal   = (state_q == StIdle) ? (in_type == FLIT_HEAD)
                                      : (in_type == FLIT_BODY || in_type == FLIT_TAIL);
        push    = accept & legal;
        send    = ~fifo_empty & (credit_q != '0);
    end

    flit_fifo #(
        .FLIT_W     (FLIT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (send),
        .din   (port.in_flit),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            out_valid_q  <= 1'b0;
            out_flit_q   <= '0;
            credit_q     <= CNT_W'(CREDITS);
            proto_err_q  <= 1'b0;
            credit_err_q <= 1'b0;
        end else begin
            out_valid_q <= send;
            out_flit_q  <= send ? fifo_dout : '0;

            // Illegal flits are consumed but never written, so framing state is untouched.
            if (accept) begin
                if (!legal) begin
                    proto_err_q <= 1'b1;
                end else begin
                    unique case (state_q)
                        StIdle:   state_q <= StPacket;
                        StPacket: if (in_type == FLIT_TAIL) state_q <= StIdle;
                    endcase
                end
            end

            if (send && !port.credit_in) begin
                credit_q <= credit_q - 1'b1;
            end else if (!send && port.credit_in) begin
                if (credit_q == CNT_W'(CREDITS)) credit_err_q <= 1'b1;
                else                             credit_q     <= credit_q + 1'b1;
            end
        end
    end

    assign port.in_ready     = ~fifo_full;
    assign port.out_valid    = out_valid_q;
    assign port.out_flit     = out_flit_q;
    assign port.credit_count = credit_q;
    assign port.busy         = (state_q == StPacket);
    assign port.proto_err    = proto_err_q;
    assign port.credit_err   = credit_err_q;

endmodule

// File: tb/tb_output_port.sv
// Directed bench for output_port: framing, credit flow control, FIFO backpressure and reset.
module tb_output_port;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   sent;
    int   accepted;
    logic [31:0] flits [8];

    output_port_if #(.FLIT_W(32), .CNT_W(3)) bus ();

    output_port #(
        .FLIT_W     (32),
        .CREDITS    (6),
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .port  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_flit   = '0;
        bus.credit_in = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_flit   = '0;
        bus.credit_in = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_flit", 64'(bus.out_flit), 64'd0);
        chk("rst_credit", 64'(bus.credit_count), 64'd6);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_proto_err", 64'(bus.proto_err), 64'd0);
        chk("rst_credit_err", 64'(bus.credit_err), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Four-flit packet, no credit return.
        bus.in_valid = 1'b1;
        bus.in_flit  = 32'h4000_0001;
        tick();
        chk("p1_busy_head", 64'(bus.busy), 64'd1);
        chk("p1_lat_valid", 64'(bus.out_valid), 64'd0);
        bus.in_flit = 32'h8000_0002;
        tick();
        chk("p1_f0", 64'(bus.out_flit), 64'h4000_0001);
        chk("p1_f0_valid", 64'(bus.out_valid), 64'd1);
        chk("p1_cnt5", 64'(bus.credit_count), 64'd5);
        bus.in_flit = 32'h8000_0003;
        tick();
        chk("p1_f1", 64'(bus.out_flit), 64'h8000_0002);
        chk("p1_busy_body", 64'(bus.busy), 64'd1);
        bus.in_flit = 32'hC000_0004;
        tick();
        chk("p1_f2", 64'(bus.out_flit), 64'h8000_0003);
        chk("p1_busy_tail", 64'(bus.busy), 64'd0);
        bus.in_valid = 1'b0;
        bus.in_flit  = '0;
        tick();
        chk("p1_f3", 64'(bus.out_flit), 64'hC000_0004);
        chk("p1_cnt2", 64'(bus.credit_count), 64'd2);
        tick();
        chk("p1_idle_valid", 64'(bus.out_valid), 64'd0);
        chk("p1_idle_flit", 64'(bus.out_flit), 64'd0);

        // Ten flits without credits: six go out, four fill the FIFO.
        do_reset();
        sent     = 0;
        accepted = 0;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_flit  = (i == 0) ? (32'h4000_0000 | 32'(i)) :
                           (i == 9) ? (32'hC000_0000 | 32'(i)) : (32'h8000_0000 | 32'(i));
            if (bus.in_ready) accepted++;
            tick();
            if (bus.out_valid) sent++;
        end
        bus.in_valid = 1'b0;
        bus.in_flit  = '0;
        chk("bp_accepted", 64'(accepted), 64'd10);
        chk("bp_sent", 64'(sent), 64'd6);
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_cnt0", 64'(bus.credit_count), 64'd0);
        tick();
        chk("bp_stall_valid", 64'(bus.out_valid), 64'd0);
        bus.credit_in = 1'b1;
        tick();
        bus.credit_in = 1'b0;
        chk("bp_cr_cnt1", 64'(bus.credit_count), 64'd1);
        chk("bp_cr_no_send", 64'(bus.out_valid), 64'd0);
        tick();
        chk("bp_release_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_release_flit", 64'(bus.out_flit), 64'h8000_0006);
        chk("bp_release_cnt", 64'(bus.credit_count), 64'd0);
        chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
        tick();
        chk("bp_one_only", 64'(bus.out_valid), 64'd0);

        // Sustained traffic with credits returned on send cycles.
        do_reset();
        flits[0] = 32'h4000_0100;
        for (int i = 1; i < 5; i++) flits[i] = 32'h8000_0100 | 32'(i);
        flits[5] = 32'hC000_0105;
        for (int k = 0; k < 7; k++) begin
            bus.in_valid  = (k < 6);
            bus.in_flit   = (k < 6) ? flits[k] : '0;
            bus.credit_in = (k >= 1);
            tick();
            if (k >= 1) begin
                chk("ss_valid", 64'(bus.out_valid), 64'd1);
                chk("ss_flit", 64'(bus.out_flit), 64'(flits[k-1]));
                chk("ss_cnt", 64'(bus.credit_count), 64'd6);
            end
        end
        bus.in_valid  = 1'b0;
        bus.credit_in = 1'b0;
        chk("ss_credit_err", 64'(bus.credit_err), 64'd0);

        // Body offered in IDLE is swallowed and flagged.
        do_reset();
        bus.in_valid = 1'b1;
        bus.in_flit  = 32'h8000_00AA;
        chk("pe_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_flit  = '0;
        chk("pe_proto_err", 64'(bus.proto_err), 64'd1);
        chk("pe_busy", 64'(bus.busy), 64'd0);
        tick();
        chk("pe_dropped", 64'(bus.out_valid), 64'd0);
        bus.in_valid = 1'b1;
        bus.in_flit  = 32'h4000_0055;
        tick();
        bus.in_valid = 1'b0;
        bus.in_flit  = '0;
        chk("pe_head_busy", 64'(bus.busy), 64'd1);
        tick();
        chk("pe_head_out", 64'(bus.out_flit), 64'h4000_0055);
        chk("pe_sticky", 64'(bus.proto_err), 64'd1);

        // Credit return at full count.
        do_reset();
        bus.credit_in = 1'b1;
        tick();
        bus.credit_in = 1'b0;
        chk("ce_cnt", 64'(bus.credit_count), 64'd6);
        chk("ce_flag", 64'(bus.credit_err), 64'd1);

        // Type-00 flit, then a packet left mid-flight with 3 queued and 1 credit, then reset.
        bus.in_valid = 1'b1;
        bus.in_flit  = 32'h0000_0077;
        tick();
        chk("mr_empty_type", 64'(bus.proto_err), 64'd1);
        for (int i = 0; i < 9; i++) begin
            bus.in_flit   = (i == 0) ? 32'h4000_0200 : (32'h8000_0200 | 32'(i));
            bus.credit_in = (i == 8);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.in_flit   = '0;
        bus.credit_in = 1'b0;
        chk("mr_pre_cnt", 64'(bus.credit_count), 64'd1);
        chk("mr_pre_busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        tick();
        chk("mr_valid", 64'(bus.out_valid), 64'd0);
        chk("mr_flit", 64'(bus.out_flit), 64'd0);
        chk("mr_cnt", 64'(bus.credit_count), 64'd6);
        chk("mr_busy", 64'(bus.busy), 64'd0);
        chk("mr_proto_err", 64'(bus.proto_err), 64'd0);
        chk("mr_credit_err", 64'(bus.credit_err), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("mr_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        chk("mr_fifo_empty", 64'(bus.out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/output_port.md
# output_port

Transmit end of a router link. Accepts 32-bit flits from the crossbar, holds them in a small FIFO, and forwards them to the downstream router's input port under credit-based flow control. It owns the credit count for the downstream virtual buffer and enforces wormhole packet framing (head … tail) on the link.

## Interface
- FLIT_W, 32, flit width; bits [FLIT_W-1:FLIT_W-2] are the flit type.
- CREDITS, 6, downstream buffer depth in flits; also the reset credit count.
- FIFO_DEPTH, 4, local output FIFO depth (power of two).

- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  reset: synchronous, active-low.
- in_valid  in  1  crossbar offers a flit.
- in_flit  in  FLIT_W  offered flit.
- in_ready  out  1  FIFO can accept; transfer when in_valid & in_ready.
- out_valid  out  1  out_flit is a valid flit this cycle.
- out_flit  out  FLIT_W  flit to downstream; all-zero when out_valid=0.
- credit_in  in  1  one-cycle pulse: downstream freed one slot.
- credit_count  out  $clog2(CREDITS+1)  current credits.
- busy  out  1  packet in progress (head accepted, tail not yet accepted).
- proto_err  out  1  sticky: framing violation seen.
- credit_err  out  1  sticky: credit_in received at full count.

## Operation
- Flit type: 00 invalid/empty, 01 head, 10 body, 11 tail. Downstream treats type 00 as an empty slot, so an idle link drives out_flit = 0.
- Framing FSM on accepted flits:
  - IDLE: a head moves to PACKET and sets busy. A body or tail is dropped (not written) and sets proto_err.
  - PACKET: body stays in PACKET. Tail returns to IDLE and clears busy. A head is dropped and sets proto_err.
  - Type 00 with in_valid: dropped and sets proto_err, in any state.
- in_ready = FIFO not full. It does not depend on flit type; illegal flits are consumed and discarded.
- Send rule: each cycle the FIFO is non-empty and credit_count > 0, pop one flit into the out_flit register and decrement credit_count. Otherwise out_valid = 0 and out_flit = 0.
- credit_in increments credit_count.
  - Simultaneous send and credit_in: count unchanged.
  - credit_in when count == CREDITS with no send: count held, credit_err set.
- FIFO: write and read in the same cycle are allowed when full or empty. Write when empty with a same-cycle read is not a bypass; that flit is read no earlier than the next cycle.
- proto_err and credit_err clear only on reset.

## Timing
- Reset (rst_n low at a posedge):
  - out_valid=0, out_flit=0, credit_count=CREDITS, busy=0, proto_err=0, credit_err=0.
  - FSM in IDLE, FIFO empty.
  - in_ready=1 from the first cycle after reset.
- Reset mid-packet discards FIFO contents and FSM state. Credits restore to CREDITS regardless of in-flight flits.
- Latency: a flit accepted at edge N into an empty FIFO with credit > 0 is driven on out_flit after edge N+1, for exactly one cycle.
- Throughput: one flit per cycle while credits and FIFO data are available.
- With credit_count = 0, out_valid stays 0. The first send occurs at the edge after the edge that samples credit_in.
- busy and the FSM update at the accepting edge.
- credit_count is registered; it reflects sends and credits from the previous edge.

## Structure
- Shared package noc_pkg: FLIT_W, flit-type constants (FLIT_EMPTY, FLIT_HEAD, FLIT_BODY, FLIT_TAIL), and the type-field slice positions. The input port uses the same constants.
- Sub-module flit_fifo: synchronous FIFO with parameters FLIT_W and FIFO_DEPTH, ports push/pop/full/empty/dout. The FSM, credit counter and output register stay in output_port.

## Test plan
- Reset then send head 0x4000_0001, bodies 0x8000_0002 and 0x8000_0003, tail 0xC000_0004, with credit_in held 0 -> out_flit shows the four flits on consecutive cycles, one cycle after each accept; credit_count goes 6→2; busy is 1 from the head accept through the tail accept.
- Push 10 flits back-to-back with no credit_in -> exactly 6 flits sent, then out_valid=0 and credit_count=0; in_ready drops when 4 are queued. A single credit_in pulse releases exactly one more flit on the following cycle.
- Sustained traffic with credit_in pulsed on the same cycles as sends -> credit_count stays constant; no bubbles; credit_err=0.
- Body flit 0x8000_00AA offered in IDLE -> in_ready=1, flit never appears on out_flit, proto_err=1, busy=0. A later head is accepted normally.
- credit_in pulse at full count (6) with empty FIFO -> credit_count stays 6, credit_err=1.
- rst_n asserted low mid-packet with 3 flits queued and credit_count=1 -> next cycle out_valid=0, out_flit=0, credit_count=6, busy=0, FIFO empty, errors cleared.
